// File: rtl/moesi_pkg.sv
// Shared encodings for the snooping bus controller: MOESI line states,
// request kinds, controller FSM states and the fill-state helper.
package moesi_pkg;

   localparam logic [2:0] MOESI_M = 3'b001;
   localparam logic [2:0] MOESI_O = 3'b010;
   localparam logic [2:0] MOESI_E = 3'b100;
   localparam logic [2:0] MOESI_S = 3'b101;
   localparam logic [2:0] MOESI_I = 3'b000;

   typedef enum logic [1:0] {
      REQ_RD_MISS  = 2'b00,
      REQ_WR_MISS  = 2'b01,
      REQ_UPGRADE  = 2'b10,
      REQ_RESERVED = 2'b11
   } req_type_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNOOP   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_MEM     = 3'd3,
      ST_DONE    = 3'd4
   } fsm_state_e;

   // Final line state handed to the requester once its fill completes.
   function automatic logic [2:0] fill_state(input req_type_e kind, input logic held_elsewhere);
      logic [2:0] st;
      case (kind)
         REQ_RD_MISS: st = held_elsewhere ? MOESI_S : MOESI_E;
         REQ_WR_MISS: st = MOESI_M;
         REQ_UPGRADE: st = MOESI_M;
         default:     st = MOESI_I;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr (wrapping) and grants the
// first requesting core as a one-hot vector, plus its index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int CW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [CW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [CW-1:0] grant_idx,
   output logic          grant_any
);

   int pos_s;

   // Pick the first requester at or after ptr.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      pos_s     = 0;
      for (int i = 0; i < N; i++) begin
         pos_s = (int'(ptr) + i) % N;
         if (!grant_any && req[pos_s]) begin
            grant[pos_s] = 1'b1;
            grant_idx    = CW'(pos_s);
            grant_any    = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller: grants one cache miss/upgrade at a time, broadcasts
// a snoop, gathers replies (with timeout), falls back to memory when no cache
// supplies the line, and reports the fill with its final MOESI state.
module snoop_bus_ctrl
   import moesi_pkg::*;
#(
   parameter int NUM_CORES   = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int SNP_TIMEOUT = 16,
   localparam int CW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [NUM_CORES*2-1:0]      req_type,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   output logic [NUM_CORES-1:0]        gnt,
   output logic                        snp_valid,
   output logic                        snp_read,
   output logic                        snp_write,
   output logic                        snp_invalidate,
   output logic [ADDR_W-1:0]           snp_addr,
   output logic [NUM_CORES-1:0]        snp_target,
   input  logic [NUM_CORES-1:0]        snp_resp_valid,
   input  logic [NUM_CORES-1:0]        snp_resp_shared,
   input  logic [NUM_CORES-1:0]        snp_resp_data_valid,
   input  logic [NUM_CORES*DATA_W-1:0] snp_resp_data,
   output logic                        mem_rd_req,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_rd_ack,
   input  logic [DATA_W-1:0]           mem_rd_data,
   output logic                        done_valid,
   output logic [CW-1:0]               done_core,
   output logic [2:0]                  done_state,
   output logic [DATA_W-1:0]           done_data,
   output logic                        done_src,
   output logic                        timeout_err
);

   localparam int TW = (SNP_TIMEOUT > 1) ? $clog2(SNP_TIMEOUT) : 1;

   fsm_state_e            state_r, next_s;
   logic [CW-1:0]         rr_ptr_r, core_r, best_idx_r;
   req_type_e             type_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [NUM_CORES-1:0]  target_r, resp_r, shr_r;
   logic                  have_r;
   logic [DATA_W-1:0]     best_data_r;
   logic [TW-1:0]         cnt_r;

   logic [NUM_CORES-1:0]  arb_gnt_s, new_s, new_dv_s;
   logic [CW-1:0]         arb_idx_s, cand_idx_s, win_idx_s;
   logic                  arb_any_s, cand_ok_s, all_resp_s, timeout_s, exit_s;
   logic                  any_shr_s, any_dv_s;
   req_type_e             sel_type_s;
   logic [ADDR_W-1:0]     sel_addr_s;
   logic [DATA_W-1:0]     cand_data_s, win_data_s;

   rr_arbiter #(.N(NUM_CORES), .CW(CW)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_r),
      .grant     (arb_gnt_s),
      .grant_idx (arb_idx_s),
      .grant_any (arb_any_s)
   );

   // Grant pulse belongs to the IDLE cycle in which the request is accepted.
   always_comb begin
      if ((state_r == ST_IDLE) && !rst) begin
         gnt = arb_gnt_s;
      end else begin
         gnt = '0;
      end
   end

   // Select the granted core's request fields.
   always_comb begin
      sel_type_s = REQ_RD_MISS;
      sel_addr_s = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (arb_gnt_s[i]) begin
            sel_type_s = req_type_e'(req_type[i*2 +: 2]);
            sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   // Merge this cycle's first-time target replies with the sticky ones;
   // the lowest-index data supplier wins across all cycles.
   always_comb begin
      new_s       = snp_resp_valid & target_r & ~resp_r;
      new_dv_s    = new_s & snp_resp_data_valid;
      all_resp_s  = ((resp_r | new_s) == target_r);
      timeout_s   = !all_resp_s && (cnt_r == TW'(SNP_TIMEOUT - 1));
      exit_s      = all_resp_s || timeout_s;
      any_shr_s   = |(shr_r | (new_s & snp_resp_shared));
      cand_ok_s   = |new_dv_s;
      any_dv_s    = have_r || cand_ok_s;
      cand_idx_s  = '0;
      cand_data_s = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (new_dv_s[i]) begin
            cand_idx_s  = CW'(i);
            cand_data_s = snp_resp_data[i*DATA_W +: DATA_W];
         end else begin
            cand_idx_s = cand_idx_s;
         end
      end
      if (have_r && (!cand_ok_s || (best_idx_r < cand_idx_s))) begin
         win_idx_s  = best_idx_r;
         win_data_s = best_data_r;
      end else begin
         win_idx_s  = cand_idx_s;
         win_data_s = cand_data_s;
      end
   end

   // Next-state logic for the transaction FSM.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arb_any_s) begin
               next_s = (sel_type_s == REQ_RESERVED) ? ST_DONE : ST_SNOOP;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_SNOOP: next_s = ST_COLLECT;
         ST_COLLECT: begin
            if (!exit_s) begin
               next_s = ST_COLLECT;
            end else if ((type_r == REQ_UPGRADE) || any_dv_s) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_MEM;
            end
         end
         ST_MEM: next_s = mem_rd_ack ? ST_DONE : ST_MEM;
         ST_DONE: next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // State, transaction context and registered outputs; outputs default to 0
   // every cycle and are set only for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         rr_ptr_r       <= '0;
         core_r         <= '0;
         type_r         <= REQ_RD_MISS;
         addr_r         <= '0;
         target_r       <= '0;
         resp_r         <= '0;
         shr_r          <= '0;
         have_r         <= 1'b0;
         best_idx_r     <= '0;
         best_data_r    <= '0;
         cnt_r          <= '0;
         snp_valid      <= 1'b0;
         snp_read       <= 1'b0;
         snp_write      <= 1'b0;
         snp_invalidate <= 1'b0;
         snp_addr       <= '0;
         snp_target     <= '0;
         mem_rd_req     <= 1'b0;
         mem_addr       <= '0;
         done_valid     <= 1'b0;
         done_core      <= '0;
         done_state     <= MOESI_I;
         done_data      <= '0;
         done_src       <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state_r        <= next_s;
         snp_valid      <= 1'b0;
         snp_read       <= 1'b0;
         snp_write      <= 1'b0;
         snp_invalidate <= 1'b0;
         snp_addr       <= '0;
         snp_target     <= '0;
         mem_rd_req     <= 1'b0;
         mem_addr       <= '0;
         done_valid     <= 1'b0;
         done_core      <= '0;
         done_state     <= MOESI_I;
         done_data      <= '0;
         done_src       <= 1'b0;
         timeout_err    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (arb_any_s) begin
                  rr_ptr_r    <= (arb_idx_s == CW'(NUM_CORES - 1)) ? '0 : arb_idx_s + CW'(1);
                  core_r      <= arb_idx_s;
                  type_r      <= sel_type_s;
                  addr_r      <= sel_addr_s;
                  target_r    <= ~arb_gnt_s;
                  resp_r      <= '0;
                  shr_r       <= '0;
                  have_r      <= 1'b0;
                  best_idx_r  <= '0;
                  best_data_r <= '0;
                  cnt_r       <= '0;
                  if (sel_type_s == REQ_RESERVED) begin
                     done_valid <= 1'b1;
                     done_core  <= arb_idx_s;
                  end else begin
                     snp_valid      <= 1'b1;
                     snp_read       <= (sel_type_s == REQ_RD_MISS);
                     snp_write      <= (sel_type_s == REQ_WR_MISS);
                     snp_invalidate <= (sel_type_s == REQ_UPGRADE);
                     snp_addr       <= sel_addr_s;
                     snp_target     <= ~arb_gnt_s;
                  end
               end
            end
            ST_COLLECT: begin
               resp_r      <= resp_r | new_s;
               shr_r       <= shr_r | (new_s & snp_resp_shared);
               have_r      <= have_r | cand_ok_s;
               best_idx_r  <= win_idx_s;
               best_data_r <= win_data_s;
               cnt_r       <= cnt_r + TW'(1);
               if (exit_s) begin
                  timeout_err <= timeout_s;
                  if (next_s == ST_DONE) begin
                     done_valid <= 1'b1;
                     done_core  <= core_r;
                     if (type_r == REQ_UPGRADE) begin
                        done_state <= MOESI_M;
                     end else begin
                        done_state <= fill_state(type_r, any_shr_s || any_dv_s);
                        done_data  <= win_data_s;
                        done_src   <= 1'b1;
                     end
                  end else begin
                     mem_rd_req <= 1'b1;
                     mem_addr   <= addr_r;
                  end
               end
            end
            ST_MEM: begin
               if (mem_rd_ack) begin
                  done_valid <= 1'b1;
                  done_core  <= core_r;
                  done_state <= fill_state(type_r, |shr_r);
                  done_data  <= mem_rd_data;
               end else begin
                  mem_rd_req <= 1'b1;
                  mem_addr   <= addr_r;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule
